bus_reg_writer: RTL and testbench

BUS_REG_WRITER -- requirements
Module: bus_reg_writer

---
 rtl/bus_reg_pkg.sv | 27 ++
 rtl/reg_bank8.sv | 42 ++++
 rtl/bus_reg_writer.sv | 134 +++++++++++++
 tb/tb_bus_reg_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_reg_pkg.sv
// -----------------------------------------------------------------------------
// bus_reg_pkg
// Purpose : Shared constants, FSM state encoding and a small address helper for
//           the bus register writer and its register bank.
// Contents: NUM_REGS, DATA_W, ADDR_W, CNT_W, BEAT_CNT_MAX, state_t, addr_inc()
// -----------------------------------------------------------------------------
package bus_reg_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int CNT_W    = 8;

    localparam logic [CNT_W-1:0] BEAT_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Register index advance; the natural 3-bit wrap gives modulo-8 order.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/reg_bank8.sv
// -----------------------------------------------------------------------------
// reg_bank8
// Purpose : 8 x 16-bit register file with a single indexed write port. Every
//           entry is exposed in parallel so an external 8-to-1 bus mux can read
//           any of them without a read port.
// Ports   : clk      - rising-edge clock
//           reset_n  - synchronous active-low reset, clears all entries
//           we_i     - write enable
//           waddr_i  - index of the entry to write
//           wdata_i  - write data
//           regs_o   - all entries, regs_o[0] is entry 0
// -----------------------------------------------------------------------------
module reg_bank8
    import bus_reg_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                waddr_i,
    input  logic [DATA_W-1:0]                wdata_i,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_o
);

    // Flops rather than a RAM array: all eight entries must be visible at once.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] entry_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    entry_q <= '0;
                end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
                    entry_q <= wdata_i;
                end
            end

            assign regs_o[gi] = entry_q;
        end
    endgenerate

endmodule

// File: rtl/bus_reg_writer.sv
// -----------------------------------------------------------------------------
// bus_reg_writer
// Purpose : Accepts a write request (start index + burst length), then writes
//           each valid Bus beat into consecutive registers of an 8-entry bank,
//           wrapping 7 -> 0. Flags stray beats and counts written beats.
// Ports   : clk, reset_n         - clock, synchronous active-low reset
//           Bus                  - 16-bit write data beat
//           Dst                  - starting register index
//           burst_len            - beats minus one
//           wr_req               - start a transaction (ignored while busy)
//           bus_valid            - Bus carries a beat this cycle
//           reg_Out1..reg_Out8   - register contents (index 0..7)
//           busy                 - transaction in progress (BURST or DONE)
//           wr_done              - one-cycle pulse after the final beat
//           stray_err            - one-cycle pulse for a beat seen while idle
//           beat_count           - saturating count of written beats
// -----------------------------------------------------------------------------
module bus_reg_writer
    import bus_reg_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] Bus,
    input  logic [ADDR_W-1:0] Dst,
    input  logic [ADDR_W-1:0] burst_len,
    input  logic              wr_req,
    input  logic              bus_valid,
    output logic [DATA_W-1:0] reg_Out1,
    output logic [DATA_W-1:0] reg_Out2,
    output logic [DATA_W-1:0] reg_Out3,
    output logic [DATA_W-1:0] reg_Out4,
    output logic [DATA_W-1:0] reg_Out5,
    output logic [DATA_W-1:0] reg_Out6,
    output logic [DATA_W-1:0] reg_Out7,
    output logic [DATA_W-1:0] reg_Out8,
    output logic              busy,
    output logic              wr_done,
    output logic              stray_err,
    output logic [CNT_W-1:0]  beat_count
);

    state_t                          state_q;
    logic [ADDR_W-1:0]               addr_q;
    logic [ADDR_W-1:0]               beats_left_q;
    logic                            busy_q;
    logic                            wr_done_q;
    logic                            stray_err_q;
    logic [CNT_W-1:0]                beat_count_q;
    logic [CNT_W-1:0]                beat_count_d;
    logic                            beat_we;
    logic [NUM_REGS-1:0][DATA_W-1:0] bank_regs;

    // A beat is written only while bursting; idle and done beats never land.
    assign beat_we = (state_q == ST_BURST) && bus_valid;

    always_comb begin
        beat_count_d = beat_count_q;
        if (beat_we && (beat_count_q != BEAT_CNT_MAX)) begin
            beat_count_d = beat_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            busy_q       <= 1'b0;
            wr_done_q    <= 1'b0;
            stray_err_q  <= 1'b0;
            beat_count_q <= '0;
        end else begin
            wr_done_q    <= 1'b0;
            stray_err_q  <= 1'b0;
            beat_count_q <= beat_count_d;
            case (state_q)
                ST_IDLE: begin
                    // A request wins over a simultaneous beat: that beat is
                    // dropped silently rather than reported as stray.
                    if (wr_req) begin
                        addr_q       <= Dst;
                        beats_left_q <= burst_len;
                        state_q      <= ST_BURST;
                        busy_q       <= 1'b1;
                    end else if (bus_valid) begin
                        stray_err_q  <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (bus_valid) begin
                        addr_q <= addr_inc(addr_q);
                        if (beats_left_q == '0) begin
                            state_q   <= ST_DONE;
                            wr_done_q <= 1'b1;
                        end else begin
                            beats_left_q <= beats_left_q - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    reg_bank8 u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (beat_we),
        .waddr_i (addr_q),
        .wdata_i (Bus),
        .regs_o  (bank_regs)
    );

    assign reg_Out1   = bank_regs[0];
    assign reg_Out2   = bank_regs[1];
    assign reg_Out3   = bank_regs[2];
    assign reg_Out4   = bank_regs[3];
    assign reg_Out5   = bank_regs[4];
    assign reg_Out6   = bank_regs[5];
    assign reg_Out7   = bank_regs[6];
    assign reg_Out8   = bank_regs[7];
    assign busy       = busy_q;
    assign wr_done    = wr_done_q;
    assign stray_err  = stray_err_q;
    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_bus_reg_writer.sv
module tb_bus_reg_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] Bus = '0;
    logic [2:0]  Dst = '0;
    logic [2:0]  burst_len = '0;
    logic        wr_req = 1'b0;
    logic        bus_valid = 1'b0;
    logic [15:0] reg_Out1, reg_Out2, reg_Out3, reg_Out4;
    logic [15:0] reg_Out5, reg_Out6, reg_Out7, reg_Out8;
    logic        busy, wr_done, stray_err;
    logic [7:0]  beat_count;

    logic [7:0][15:0] obs_regs;
    assign obs_regs = {reg_Out8, reg_Out7, reg_Out6, reg_Out5,
                       reg_Out4, reg_Out3, reg_Out2, reg_Out1};

    bus_reg_writer dut (
        .clk(clk), .reset_n(reset_n), .Bus(Bus), .Dst(Dst),
        .burst_len(burst_len), .wr_req(wr_req), .bus_valid(bus_valid),
        .reg_Out1(reg_Out1), .reg_Out2(reg_Out2), .reg_Out3(reg_Out3),
        .reg_Out4(reg_Out4), .reg_Out5(reg_Out5), .reg_Out6(reg_Out6),
        .reg_Out7(reg_Out7), .reg_Out8(reg_Out8),
        .busy(busy), .wr_done(wr_done), .stray_err(stray_err),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: kind 2'b10 = wr_done event, 2'b01 = stray_err event.
    typedef struct packed {
        logic [1:0]       kind;
        logic [7:0][15:0] regs;
        logic [7:0]       cnt;
    } exp_t;
    exp_t sb[$];

    // Reference model of the writer
    logic [7:0][15:0] m_regs;
    int               m_cnt;
    logic [2:0]       m_addr;
    logic [2:0]       m_left;
    bit               m_busy;
    bit               m_in_done;

    task automatic push_exp(input logic [1:0] kind);
        exp_t e;
        e.kind = kind;
        e.regs = m_regs;
        e.cnt  = 8'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_in_done = 1'b0;
    endtask

    task automatic start(input logic [2:0] dst, input logic [2:0] len, input bit with_valid);
        Dst = dst; burst_len = len; wr_req = 1'b1; bus_valid = with_valid;
        if (!m_busy && !m_in_done) begin
            m_busy = 1'b1; m_addr = dst; m_left = len;
        end
        tick();
        wr_req = 1'b0; bus_valid = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        bit last;
        last = 1'b0;
        Bus = d; bus_valid = 1'b1;
        if (m_busy) begin
            m_regs[m_addr] = d;
            if (m_cnt < 255) m_cnt++;
            if (m_left == 3'd0) begin
                push_exp(2'b10);
                m_busy = 1'b0;
                last = 1'b1;
            end else begin
                m_addr = m_addr + 3'd1;
                m_left = m_left - 3'd1;
            end
        end else if (!m_in_done) begin
            push_exp(2'b01);
        end
        tick();
        bus_valid = 1'b0;
        if (last) m_in_done = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; wr_req = 1'b1; bus_valid = 1'b1; Dst = 3'd2; Bus = 16'hFFFF;
        tick();
        tick();
        chk("pending_at_reset", sb.size(), 0);
        sb.delete();
        m_regs = '0; m_cnt = 0; m_addr = '0; m_left = '0; m_busy = 0; m_in_done = 0;
        for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i + 1), obs_regs[i], 16'h0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_stray", stray_err, 0);
        chk("rst_count", beat_count, 0);
        reset_n = 1'b1; wr_req = 1'b0; bus_valid = 1'b0; Bus = '0; Dst = '0;
        tick();
    endtask

    // Event monitor: pops one expectation per wr_done / stray_err pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (wr_done || stray_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_evt", {30'd0, wr_done, stray_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("txn %s cnt=%0d regs=%h", wr_done ? "done " : "stray", beat_count, obs_regs);
                chk("evt_kind", {30'd0, wr_done, stray_err}, {30'd0, e.kind});
                for (int i = 0; i < 8; i++) chk($sformatf("evt_reg%0d", i + 1), obs_regs[i], e.regs[i]);
                chk("evt_cnt", beat_count, e.cnt);
            end
        end
    end

    initial begin
        m_regs = '0; m_cnt = 0; m_addr = '0; m_left = '0; m_busy = 0; m_in_done = 0;
        do_reset();

        // Single write to index 3
        start(3'd3, 3'd0, 1'b0);
        chk("single_busy", busy, 1);
        beat(16'hA5A5);
        chk("single_out4", reg_Out4, 16'hA5A5);
        for (int i = 0; i < 8; i++) if (i != 3) chk($sformatf("single_other%0d", i + 1), obs_regs[i], 16'h0);
        chk("single_done", wr_done, 1);
        tick();
        chk("single_done_clr", wr_done, 0);
        chk("single_idle", busy, 0);

        // Wrapping burst from index 6
        do_reset();
        start(3'd6, 3'd3, 1'b0);
        beat(16'd1); beat(16'd2); beat(16'd3); beat(16'd4);
        chk("wrap_out7", reg_Out7, 16'd1);
        chk("wrap_out8", reg_Out8, 16'd2);
        chk("wrap_out1", reg_Out1, 16'd3);
        chk("wrap_out2", reg_Out2, 16'd4);
        chk("wrap_out3", reg_Out3, 16'd0);
        chk("wrap_count", beat_count, 8'd4);
        tick();

        // Stalled two-beat burst
        do_reset();
        start(3'd2, 3'd1, 1'b0);
        beat(16'h1111);
        chk("stall_done0", wr_done, 0);
        repeat (3) begin
            tick();
            chk("stall_busy", busy, 1);
            chk("stall_nodone", wr_done, 0);
        end
        beat(16'h2222);
        chk("stall_done", wr_done, 1);
        chk("stall_out3", reg_Out3, 16'h1111);
        chk("stall_out4", reg_Out4, 16'h2222);
        chk("stall_count", beat_count, 8'd2);
        tick();
        chk("stall_idle", busy, 0);

        // Stray beat, ignored requests, beat during acceptance and DONE
        do_reset();
        beat(16'hDEAD);
        chk("stray_pulse", stray_err, 1);
        chk("stray_busy", busy, 0);
        tick();
        chk("stray_clr", stray_err, 0);
        start(3'd1, 3'd2, 1'b1);
        chk("accept_nostray", stray_err, 0);
        beat(16'h0A0A);
        Dst = 3'd5; burst_len = 3'd7; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("ignreq_busy", busy, 1);
        beat(16'h0B0B);
        beat(16'h0C0C);
        chk("ignreq_out2", reg_Out2, 16'h0A0A);
        chk("ignreq_out3", reg_Out3, 16'h0B0B);
        chk("ignreq_out4", reg_Out4, 16'h0C0C);
        chk("ignreq_out6", reg_Out6, 16'h0);
        wr_req = 1'b1; Dst = 3'd0;
        beat(16'hFFFF);
        wr_req = 1'b0;
        chk("done_ign_busy", busy, 0);
        chk("done_ign_stray", stray_err, 0);
        chk("done_ign_out1", reg_Out1, 16'h0);
        chk("done_ign_count", beat_count, 8'd3);

        // Reset mid-burst
        do_reset();
        start(3'd0, 3'd4, 1'b0);
        beat(16'h1234); beat(16'h5678);
        chk("mid_out1", reg_Out1, 16'h1234);
        reset_n = 1'b0;
        tick();
        sb.delete();
        m_regs = '0; m_cnt = 0; m_busy = 0; m_in_done = 0;
        for (int i = 0; i < 8; i++) chk($sformatf("mid_reg%0d", i + 1), obs_regs[i], 16'h0);
        chk("mid_busy", busy, 0);
        chk("mid_done", wr_done, 0);
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            chk("mid_post_done", wr_done, 0);
            chk("mid_post_busy", busy, 0);
        end

        // Saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            start(3'(i % 8), 3'd0, 1'b0);
            beat(16'(i));
            tick();
        end
        chk("sat_count", beat_count, 8'd255);

        tick();
        chk("pending_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
